data_sram_bridge: RTL

Memory-stage load/store bridge between the pipeline's M stage and the data-side SRAM-like bus. It converts one M-stage access into a single bus transaction: byte-lane replication on stores, lane extraction plus sign/zero extension on loads. It holds `stall_m` until the bus answers, and keeps the loaded word stable until the pipeline advances. It is placed directly downstream of the datapath's `ALUOutM`/`WriteDataM`/`MemWriteM` outputs and produces `ReadDataM`.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_load_ext.sv | 35 +++
 rtl/data_sram_bridge.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the M-stage memory bridge: size codes, FSM states, alignment check.
// Pure declarations; no latency or flow-control behaviour of its own.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    // Size code 11 is handled as a word access.
    function automatic logic misaligned(input logic [1:0] a, input logic [1:0] sz);
        logic r;
        case (sz)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = a[0];
            SZ_WORD: r = |a;
            default: r = |a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load lane select plus sign/zero extension from the latched address and size.
// Purely combinational, zero latency; no flow control.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[7:0];
        case (addr)
            2'd0: w_byte = rdata[7:0];
            2'd1: w_byte = rdata[15:8];
            2'd2: w_byte = rdata[23:16];
            2'd3: w_byte = rdata[31:24];
            default: w_byte = rdata[7:0];
        endcase
        w_half = addr[1] ? rdata[31:16] : rdata[15:0];

        ext = rdata;
        case (size)
            SZ_BYTE: ext = {{24{sign & w_byte[7]}}, w_byte};
            SZ_HALF: ext = {{16{sign & w_half[15]}}, w_half};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/data_sram_bridge.sv
// M-stage load/store to SRAM-like bus bridge; one transaction per access, min 3 M-stage cycles.
// Stalls the pipeline until data_ok, holds the request until addr_ok, holds the load result until m_adv.
module data_sram_bridge
    import mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_en_m,
    input  logic          mem_write_m,
    input  logic [1:0]    mem_size_m,
    input  logic          mem_sign_m,
    input  logic [AW-1:0] alu_out_m,
    input  logic [DW-1:0] write_data_m,
    input  logic          m_adv,
    output logic [DW-1:0] read_data_m,
    output logic          stall_m,
    output logic          addr_err_m,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [DW-1:0] data_wdata,
    input  logic          data_addr_ok,
    input  logic          data_data_ok,
    input  logic [DW-1:0] data_rdata
);

    mem_state_e    r_state;
    mem_state_e    w_next;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_size;
    logic          r_sign;
    logic          r_wr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdq;

    logic          w_misal;
    logic          w_go;
    logic          w_issue;
    logic [DW-1:0] w_wdata_rep;
    logic [DW-1:0] w_ext;

    assign w_misal    = misaligned(alu_out_m[1:0], mem_size_m);
    assign w_go       = mem_en_m & ~w_misal;
    assign w_issue    = (r_state == IDLE) & w_go;
    assign addr_err_m = mem_en_m & w_misal;
    assign stall_m    = w_go & (r_state != DONE);

    always_comb begin
        case (mem_size_m)
            SZ_BYTE: w_wdata_rep = {4{write_data_m[7:0]}};
            SZ_HALF: w_wdata_rep = {2{write_data_m[15:0]}};
            default: w_wdata_rep = write_data_m;
        endcase
    end

    mem_load_ext u_load_ext (
        .rdata (data_rdata),
        .addr  (r_addr[1:0]),
        .size  (r_size),
        .sign  (r_sign),
        .ext   (w_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_size  <= '0;
            r_sign  <= 1'b0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_rdq   <= '0;
        end else begin
            r_state <= w_next;
            if (w_issue) begin
                r_addr  <= alu_out_m;
                r_size  <= mem_size_m;
                r_sign  <= mem_sign_m;
                r_wr    <= mem_write_m;
                r_wdata <= w_wdata_rep;
            end
            if ((r_state == WAIT) && data_data_ok && !r_wr) begin
                r_rdq <= w_ext;
            end
        end
    end

    // The IDLE request comes straight from the live inputs so an access can be accepted in cycle 0;
    // afterwards the latched copy keeps the bus fields stable. rst gates data_req so it drops at once.
    always_comb begin
        w_next      = r_state;
        data_req    = 1'b0;
        data_wr     = r_wr;
        data_size   = r_size;
        data_addr   = r_addr;
        data_wdata  = r_wdata;
        read_data_m = '0;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    data_req   = rst;
                    data_wr    = mem_write_m;
                    data_size  = mem_size_m;
                    data_addr  = alu_out_m;
                    data_wdata = w_wdata_rep;
                    w_next     = data_addr_ok ? WAIT : REQ;
                end
            end
            REQ: begin
                data_req = rst;
                if (data_addr_ok) w_next = WAIT;
            end
            WAIT: begin
                if (data_data_ok) w_next = DONE;
            end
            DONE: begin
                read_data_m = r_rdq;
                if (m_adv) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
